// File: rtl/flag_sequencer.sv
// flag_sequencer: steps the pride flag selector on frame boundaries from a frame timer and next/prev/pause buttons.
// Define FLAG_SEQ_DEBOUNCE_EN to add per-button frame-based debouncing ahead of the edge detectors.
module flag_sequencer #(
    parameter int FRAMES_PER_FLAG = 120,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_pause,
    input  logic [7:0] count,
    output logic [7:0] selector,
    output logic       paused,
    output logic       flag_changed
);
    localparam logic       ST_RUN    = 1'b0;
    localparam logic       ST_PAUSED = 1'b1;
    localparam logic [1:0] P_NONE    = 2'd0;
    localparam logic [1:0] P_NEXT    = 2'd1;
    localparam logic [1:0] P_PREV    = 2'd2;
    localparam logic [15:0] FC_LAST  = 16'(FRAMES_PER_FLAG - 1);

    if (FRAMES_PER_FLAG < 1 || FRAMES_PER_FLAG > 65535) begin : g_bad_fpf
        $error("FRAMES_PER_FLAG out of range");
    end
    if (DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 15) begin : g_bad_db
        $error("DEBOUNCE_FRAMES out of range");
    end

    // button bit order: [0] next, [1] prev, [2] pause
    logic [2:0] r_sync1, r_sync2, r_lvl;
    logic [2:0] w_level, w_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {btn_pause, btn_prev, btn_next};
            r_sync2 <= r_sync1;
        end
    end

`ifdef FLAG_SEQ_DEBOUNCE_EN
    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_FRAMES - 1);
    logic [2:0][3:0] r_db_cnt;
    logic [2:0]      r_db_lvl;

    // a level is accepted once it has differed from the accepted one for DEBOUNCE_FRAMES frames in a row
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db_cnt <= '0;
            r_db_lvl <= '0;
        end else if (frame_start) begin
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_db_lvl[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db_lvl[i] <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 4'd1;
                end
            end
        end
    end

    assign w_level = r_db_lvl;
`else
    assign w_level = r_sync2;
`endif

    assign w_edge = w_level & ~r_lvl;

    logic        r_state;
    logic [1:0]  r_pend;
    logic [15:0] r_fc;
    logic [7:0]  r_sel;
    logic        r_chg;

    logic [8:0]  w_inc9;
    logic [7:0]  w_next_sel, w_prev_sel, w_sel_n;
    logic [15:0] w_fc_n;
    logic [1:0]  w_pend_n;
    logic        w_state_n;

    assign w_inc9     = {1'b0, r_sel} + 9'd1;
    assign w_next_sel = (w_inc9 >= {1'b0, count}) ? 8'd0 : w_inc9[7:0];
    assign w_prev_sel = (r_sel == 8'd0) ? count - 8'd1 : r_sel - 8'd1;

    always_comb begin
        w_sel_n = r_sel;
        w_fc_n  = r_fc;
        if (frame_start) begin
            if (count == 8'd0 || r_sel >= count) begin
                w_sel_n = 8'd0;
                w_fc_n  = '0;
            end else if (r_pend == P_NEXT) begin
                w_sel_n = w_next_sel;
                w_fc_n  = '0;
            end else if (r_pend == P_PREV) begin
                w_sel_n = w_prev_sel;
                w_fc_n  = '0;
            end else if (r_state == ST_RUN && r_fc == FC_LAST) begin
                w_sel_n = w_next_sel;
                w_fc_n  = '0;
            end else if (r_state == ST_RUN) begin
                w_fc_n  = r_fc + 16'd1;
            end
        end
        // resuming always restarts the dwell time of the current flag
        if (w_edge[2] && r_state == ST_PAUSED) w_fc_n = '0;
    end

    assign w_state_n = w_edge[2] ? ~r_state : r_state;
    assign w_pend_n  = (w_edge[0] && w_edge[1]) ? P_NONE :
                       w_edge[0]                ? P_NEXT :
                       w_edge[1]                ? P_PREV :
                       frame_start              ? P_NONE : r_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lvl   <= '0;
            r_state <= ST_RUN;
            r_pend  <= P_NONE;
            r_fc    <= '0;
            r_sel   <= '0;
            r_chg   <= 1'b0;
        end else begin
            r_lvl   <= w_level;
            r_state <= w_state_n;
            r_pend  <= w_pend_n;
            r_fc    <= w_fc_n;
            r_sel   <= w_sel_n;
            r_chg   <= frame_start && (w_sel_n != r_sel);
        end
    end

    assign selector     = r_sel;
    assign paused       = (r_state == ST_PAUSED);
    assign flag_changed = r_chg;
endmodule

// File: tb/tb_flag_sequencer.sv
// tb_flag_sequencer: directed and randomized checks of flag_sequencer against a frame-level behavioural model.
module tb_flag_sequencer;
    localparam int FPF = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fs = 1'b0;
    logic       bn = 1'b0;
    logic       bp = 1'b0;
    logic       bz = 1'b0;
    logic [7:0] cnt = 8'd52;
    logic [7:0] sel;
    logic       pau;
    logic       chg;

    int  checks = 0;
    int  failures = 0;
    int  fcc = 0;
    bit  chk_on = 1'b0;

    int  m_sel = 0, m_fc = 0, m_pend = 0;
    bit  m_paused = 1'b0, m_chg = 1'b0;
    bit [3:0] hn = '0, hp = '0, hz = '0;

    always #5 clk = ~clk;

    flag_sequencer #(.FRAMES_PER_FLAG(FPF), .DEBOUNCE_FRAMES(3)) dut (
        .clk(clk), .rst(rst), .frame_start(fs),
        .btn_next(bn), .btn_prev(bp), .btn_pause(bz),
        .count(cnt), .selector(sel), .paused(pau), .flag_changed(chg)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a button press reaches the request logic two cycles after it is sampled;
    // frame actions follow the priority list using modular index arithmetic.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_sel = 0; m_fc = 0; m_pend = 0; m_paused = 0; m_chg = 0;
            hn = '0; hp = '0; hz = '0;
        end else begin
            int  old;
            bit  en, ep, ez;
            hn = {hn[2:0], bn}; hp = {hp[2:0], bp}; hz = {hz[2:0], bz};
            en = hn[2] & ~hn[3]; ep = hp[2] & ~hp[3]; ez = hz[2] & ~hz[3];
            old = m_sel;
            if (fs) begin
                if (cnt == 0 || m_sel >= cnt) begin m_sel = 0; m_fc = 0; end
                else if (m_pend == 1) begin m_sel = (m_sel + 1) % cnt; m_fc = 0; end
                else if (m_pend == 2) begin m_sel = (m_sel + cnt - 1) % cnt; m_fc = 0; end
                else if (!m_paused) begin
                    m_fc++;
                    if (m_fc == FPF) begin m_fc = 0; m_sel = (m_sel + 1) % cnt; end
                end
                m_pend = 0;
            end
            m_chg = fs && (m_sel != old);
            if (en && ep) m_pend = 0;
            else if (en) m_pend = 1;
            else if (ep) m_pend = 2;
            if (ez) begin
                m_paused = !m_paused;
                if (!m_paused) m_fc = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chg) fcc++;
        if (chk_on && !rst) begin
            chk("model_selector", sel, m_sel);
            chk("model_paused", pau, m_paused);
            chk("model_flag_changed", chg, m_chg);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame();
        fs = 1'b1; tick(1); fs = 1'b0; tick(3);
    endtask

    task automatic press(input int b);
        if (b == 0) bn = 1'b1; else if (b == 1) bp = 1'b1; else bz = 1'b1;
        tick(1);
        bn = 1'b0; bp = 1'b0; bz = 1'b0;
        tick(4);
    endtask

    initial begin
        int c0, s0;
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("reset_selector", sel, 0);
        chk("reset_paused", pau, 0);
        chk("reset_flag_changed", chg, 0);
`ifdef FLAG_SEQ_DEBOUNCE_EN
        bz = 1'b1; repeat (8) frame();
        bz = 1'b0; repeat (8) frame();
        chk("db_paused", pau, 1);
        s0 = sel;
        bn = 1'b1; tick(3); frame(); bn = 1'b0;
        repeat (8) frame();
        chk("db_glitch_selector", sel, s0);
        chk("db_glitch_paused", pau, 1);
`else
        chk_on = 1'b1;
        c0 = fcc;
        repeat (3) frame();
        chk("auto_pre4", sel, 0);
        frame();
        chk("auto_4", sel, 1);
        repeat (3) frame();
        chk("auto_pre8", sel, 1);
        frame();
        chk("auto_8", sel, 2);
        chk("auto_pulses", fcc - c0, 2);

        press(2);
        chk("pause_on", pau, 1);
        repeat (20) frame();
        chk("pause_hold", sel, 2);
        press(2);
        chk("pause_off", pau, 0);
        repeat (3) frame();
        chk("resume_pre4", sel, 2);
        frame();
        chk("resume_4", sel, 3);

        repeat (4) begin press(1); frame(); end
        chk("prev_to_51", sel, 51);
        press(0); frame();
        chk("wrap_next", sel, 0);
        press(1); frame();
        chk("wrap_prev", sel, 51);

        press(2);
        c0 = fcc;
        bn = 1'b1; bp = 1'b1; tick(1); bn = 1'b0; bp = 1'b0; tick(4);
        frame();
        chk("simul_selector", sel, 51);
        chk("simul_pulses", fcc - c0, 0);

        repeat (11) begin press(1); frame(); end
        chk("step_to_40", sel, 40);
        c0 = fcc;
        cnt = 8'd10; frame();
        chk("shrink_selector", sel, 0);
        chk("shrink_pulses", fcc - c0, 1);
        cnt = 8'd0; press(0); repeat (3) frame();
        chk("count0_selector", sel, 0);

        cnt = 8'd52;
        press(0);
        rst = 1'b1; tick(2); rst = 1'b0; tick(1);
        frame();
        chk("rst_selector", sel, 0);
        chk("rst_paused", pau, 0);
        cnt = 8'd1; c0 = fcc;
        press(0); frame();
        chk("count1_selector", sel, 0);
        chk("count1_pulses", fcc - c0, 0);

        cnt = 8'd52;
        for (int i = 0; i < 6000; i++) begin
            fs = ($urandom % 6) == 0;
            if ($urandom % 8 == 0) bn = ~bn;
            if ($urandom % 8 == 0) bp = ~bp;
            if ($urandom % 23 == 0) bz = ~bz;
            if ($urandom % 400 == 0) begin
                case ($urandom % 6)
                    0: cnt = 8'd0;
                    1: cnt = 8'd1;
                    2: cnt = 8'd2;
                    3: cnt = 8'd5;
                    4: cnt = 8'd255;
                    default: cnt = 8'd52;
                endcase
            end
            rst = ($urandom % 1500) == 0;
            tick(1);
        end
        rst = 1'b0; fs = 1'b0;
        tick(2);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/flag_sequencer.md
# flag_sequencer

Sequences the flag selector that drives the combinational flag colour mux in the pride VGA design. Owns the currently displayed flag index: auto-advances after a programmable number of frames, and accepts next/previous/pause buttons. All selector changes land on a frame boundary, so a frame never shows two flags. Sits between the button inputs, the VGA timing generator's frame pulse, and the flag mux's `selector`/`count` ports.

## Interface
- `FRAMES_PER_FLAG`, 120: frames each flag is shown in auto mode; legal range 1..65535.
- `DEBOUNCE_FRAMES`, 3: stable frames required for a button level change; used only with `FLAG_SEQ_DEBOUNCE_EN`; legal range 1..15.

- `clk` in 1: pixel clock.
- `rst` in 1: asynchronous, active-high reset.
- `frame_start` in 1: single-cycle pulse at the start of each frame, from the VGA timing generator.
- `btn_next` in 1: raw, asynchronous next-flag button, active-high.
- `btn_prev` in 1: raw, asynchronous previous-flag button, active-high.
- `btn_pause` in 1: raw, asynchronous pause-toggle button, active-high.
- `count` in 8: number of flags available from the flag mux.
- `selector` out 8: registered flag index presented to the flag mux.
- `paused` out 1: high in the PAUSED state.
- `flag_changed` out 1: one-cycle pulse when `selector` takes a new value.

## Operation
- Inputs: each button goes through a 2-flop synchroniser, then a rising-edge detector on the registered synchronised (or debounced) level.
- FSM states:
  - RUN: reset state; frame counter active.
  - PAUSED: frame counter frozen.
- Pause edge toggles RUN and PAUSED immediately. Entering RUN clears the frame counter.
- Pending register `pend` ∈ {NONE, NEXT, PREV}:
  - A next edge sets NEXT; a prev edge sets PREV. A later edge overwrites an earlier one.
  - Next and prev edges in the same cycle set NONE (the requests cancel).
  - Buttons work in both states.
- Action on each cycle with `frame_start`=1, in priority order:
  - **`count`=0:** `selector` forced to 0. `pend` cleared. Frame counter cleared.
  - **`selector` ≥ `count`:** `selector`←0. `pend` cleared. Frame counter cleared.
  - **`pend`=NEXT:** `selector`←`selector`+1, or 0 if `selector`+1 ≥ `count`. `pend` cleared. Frame counter cleared.
  - **`pend`=PREV:** `selector`←`count`−1 if `selector`=0, else `selector`−1. `pend` cleared. Frame counter cleared.
  - **RUN and frame counter = `FRAMES_PER_FLAG`−1:** advance as for NEXT. Frame counter cleared.
  - **RUN otherwise:** frame counter +1.
  - **PAUSED otherwise:** no change.
- An edge arriving in the same cycle as `frame_start` is applied at the next `frame_start`.
- Width rules:
  - Frame counter is 16 bits. Never exceeds `FRAMES_PER_FLAG`−1.
  - Index arithmetic is 9-bit internally, so `selector`+1 never overflows before the compare.
- `flag_changed` asserts only if the new `selector` differs from the old one. Example: NEXT with `count`=1 produces no pulse.

## Timing
- Reset values:
  - `selector`=0, `paused`=0, `flag_changed`=0.
  - Frame counter 0, `pend`=NONE, state RUN.
  - Synchroniser and edge flops 0, so a button held through reset yields one edge after `rst` falls.
- Button to `pend` latency: 3 `clk` edges (2 sync stages + edge register).
- `selector` and `paused` are registered.
  - `selector` updates on the `clk` edge that samples `frame_start`=1.
  - `flag_changed` is high for exactly the following cycle.
- `paused` updates on the edge that registers the pause edge.
- Reset asserted mid-operation returns all state to reset values asynchronously. Any pending request is lost.

## Configuration
- `FLAG_SEQ_DEBOUNCE_EN` defined:
  - Each synchronised button level is accepted only after it has been stable for `DEBOUNCE_FRAMES` consecutive `frame_start` pulses.
  - Per-button 4-bit counters; edge detection runs on the accepted level.
  - Added latency: up to `DEBOUNCE_FRAMES`+1 frames.
- `FLAG_SEQ_DEBOUNCE_EN` undefined:
  - Edge detection runs directly on the synchronised level.
  - `DEBOUNCE_FRAMES` is ignored and no debounce counters exist.

## Test plan
- Auto advance: reset, `count`=52, `FRAMES_PER_FLAG`=4, pulse `frame_start` 8 times -> `selector` 0→1 on pulse 4, 1→2 on pulse 8; `flag_changed` high exactly two cycles in total.
- Wrap: `selector` at 51, `count`=52, one next press then `frame_start` -> `selector`=0. Then one prev press and `frame_start` -> `selector`=51.
- Pause: pause press, 20 frames -> `paused`=1 and `selector` unchanged. Second pause press then 4 frames (`FRAMES_PER_FLAG`=4) -> `selector`+1.
- Simultaneous: next and prev edges in the same cycle, then `frame_start` in PAUSED -> `selector` unchanged, no `flag_changed`.
- Count shrink: `selector`=40, `count` changed to 10, `frame_start` -> `selector`=0 with `flag_changed` pulse. `count`=0 -> `selector` held at 0.
- Reset mid-op: NEXT pending, assert `rst` between frames, release, `frame_start` -> `selector`=0, no advance, `paused`=0. Debounce build: a 1-frame glitch on `btn_next` with `DEBOUNCE_FRAMES`=3 -> no change.
